csr_spi_master: RTL and testbench

CSR-mapped byte-wide SPI master (mode 0) that sits beside the UART on the pipeline's CSR bus and drives the board's SPI flash pins. Lets software, chiefly the boot loader, read from and program the configuration flash a byte at a time. Its rdata/valid outputs are ORed into the shared CSR return path with the counter and UART devices.

---
 rtl/csr_spi_master_pkg.sv | 30 +++
 rtl/spi_byte_shifter.sv | 96 +++++++++
 rtl/csr_spi_master.sv | 70 +++++++
 tb/tb_csr_spi_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_spi_master_pkg.sv
// Definitions shared by the CSR-bus devices: decoded address and the modify
// operation encodings with the read-modify-write helper they all use.
package csr_spi_master_pkg;

   localparam logic [11:0] CSR_SPI_ADDR = 12'h7c2;

   typedef enum logic [1:0] {
      MOD_NONE  = 2'b00,
      MOD_WRITE = 2'b01,
      MOD_SET   = 2'b10,
      MOD_CLEAR = 2'b11
   } modify_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } spi_state_e;

   function automatic logic [31:0] csr_modify(input modify_e   op,
                                              input logic [31:0] cur,
                                              input logic [31:0] operand);
      case (op)
         MOD_WRITE: return operand;
         MOD_SET:   return cur | operand;
         MOD_CLEAR: return cur & ~operand;
         default:   return cur;
      endcase
   endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: divider, SCK, MSB-first tx/rx shifting and bit count.
// busy_o rises at the start edge; done_o is high in the cycle before the last SCK fall.
module spi_byte_shifter
   import csr_spi_master_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start_i,
   input  logic [7:0] tx_byte_i,
   input  logic       miso_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] rx_byte_o,
   output logic       sck_o,
   output logic       mosi_o
);

   localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

   spi_state_e state_q, state_d;
   logic [7:0] div_q, div_d;
   logic       sck_q, sck_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [2:0] bit_q, bit_d;
   logic       done;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         sck_q   <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         sck_q   <= sck_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         bit_q   <= bit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      sck_d   = sck_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      bit_d   = bit_q;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_SHIFT;
               tx_d    = tx_byte_i;
               div_d   = '0;
               bit_d   = '0;
               sck_d   = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (div_q == DIV_TC) begin
               div_d = '0;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_d = {rx_q[6:0], miso_i};
               end else begin
                  bit_d = bit_q + 3'd1;
                  // The last fall leaves tx untouched so MOSI holds the final bit.
                  if (bit_q == 3'd7) begin
                     state_d = ST_IDLE;
                     done    = 1'b1;
                  end else begin
                     tx_d = {tx_q[6:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy_o    = (state_q == ST_SHIFT);
   assign done_o    = done;
   assign rx_byte_o = rx_q;
   assign sck_o     = sck_q;
   assign mosi_o    = tx_q[7];

endmodule

// File: rtl/csr_spi_master.sv
// CSR-mapped byte-wide SPI master: register decode, modify ALU, chip select and rx byte.
// Modifies arriving while a byte is in flight are dropped; reads are side-effect free.
module csr_spi_master
   import csr_spi_master_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        read,
   input  logic [1:0]  modify,
   input  logic [31:0] wdata,
   input  logic [11:0] addr,
   output logic [31:0] rdata,
   output logic        valid,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_csn
);

   logic        cs_active_q, cs_active_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        busy, done, start, wr_en;
   logic [7:0]  shift_rx;
   logic [31:0] reg_val, new_val;
   modify_e     mod_op;
   logic        unused_bits;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cs_active_q <= 1'b0;
         rx_byte_q   <= '0;
      end else begin
         cs_active_q <= cs_active_d;
         rx_byte_q   <= rx_byte_d;
      end
   end

   always_comb begin
      mod_op      = modify_e'(modify);
      valid       = (addr == CSR_SPI_ADDR);
      reg_val     = {22'b0, cs_active_q, busy, rx_byte_q};
      rdata       = valid ? reg_val : 32'b0;
      new_val     = csr_modify(mod_op, reg_val, wdata);
      wr_en       = valid && (mod_op != MOD_NONE) && !busy;
      start       = wr_en && new_val[8];
      cs_active_d = wr_en ? new_val[9] : cs_active_q;
      rx_byte_d   = done ? shift_rx : rx_byte_q;
   end

   assign spi_csn     = ~cs_active_q;
   assign unused_bits = ^{read, new_val[31:10]};

   spi_byte_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk       (clk),
      .rstn      (rstn),
      .start_i   (start),
      .tx_byte_i (new_val[7:0]),
      .miso_i    (spi_miso),
      .busy_o    (busy),
      .done_o    (done),
      .rx_byte_o (shift_rx),
      .sck_o     (spi_sck),
      .mosi_o    (spi_mosi)
   );

endmodule

// File: tb/tb_csr_spi_master.sv
// Self-checking bench for csr_spi_master: directed scenarios plus random CSR
// traffic against a cycle-count reference model and a byte-level slave.
module tb_csr_spi_master;
   import csr_spi_master_pkg::*;

   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        read = 1'b0;
   logic [1:0]  modify = 2'b00;
   logic [31:0] wdata = '0;
   logic [11:0] addr = CSR_SPI_ADDR;
   logic [31:0] rdata;
   logic        valid;
   logic        spi_sck, spi_mosi, spi_csn, spi_miso;

   int checks = 0;
   int errors = 0;

   csr_spi_master #(.CLK_DIV(D)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .read     (read),
      .modify   (modify),
      .wdata    (wdata),
      .addr     (addr),
      .rdata    (rdata),
      .valid    (valid),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .spi_csn  (spi_csn)
   );

   always #5 clk = ~clk;

   // Slave: presents the byte MSB first, advancing one bit after every SCK rise.
   logic [7:0] slv_byte = 8'h00;
   logic [7:0] slv_next = 8'h00;
   int         rise_n = 0;
   int         rise_base = 0;
   longint     rise_t[$];
   logic       mosi_q[$];

   assign spi_miso = slv_byte[3'(7 - (rise_n - rise_base))];

   always @(posedge spi_sck) begin
      rise_t.push_back($time);
      mosi_q.push_back(spi_mosi);
      rise_n++;
   end

   // Reference model: register contents plus remaining busy cycles.
   int         m_left = 0;
   logic       m_cs = 1'b0;
   logic [7:0] m_rx = 8'h00;
   logic [7:0] m_tx = 8'h00;
   logic [7:0] m_exp = 8'h00;

   function automatic logic [31:0] model_r();
      return {22'b0, m_cs, (m_left != 0), m_rx};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic [31:0] n;
      logic        fin;
      logic [7:0]  seen;
      fin = 1'b0;
      seen = 8'h00;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_rx = m_exp;
            fin = 1'b1;
         end
      end else if (modify != 2'b00 && addr == CSR_SPI_ADDR) begin
         case (modify)
            2'b01:   n = wdata;
            2'b10:   n = model_r() | wdata;
            default: n = model_r() & ~wdata;
         endcase
         m_cs = n[9];
         if (n[8]) begin
            m_left    = 16 * D;
            m_tx      = n[7:0];
            m_exp     = slv_next;
            slv_byte  = slv_next;
            rise_base = rise_n;
         end
      end
      @(posedge clk);
      #1;
      chk("valid", {31'b0, valid}, {31'b0, addr == CSR_SPI_ADDR});
      chk("rdata", rdata, (addr == CSR_SPI_ADDR) ? model_r() : 32'h0);
      chk("csn", {31'b0, spi_csn}, {31'b0, ~m_cs});
      if (m_left == 0) chk("sck_idle", {31'b0, spi_sck}, 32'h0);
      if (fin) begin
         chk("sck_rises", rise_n - rise_base, 8);
         if (rise_n - rise_base >= 8) begin
            for (int i = 0; i < 8; i++) seen = {seen[6:0], mosi_q[rise_base + i]};
         end
         chk("mosi_byte", {24'b0, seen}, {24'b0, m_tx});
      end
   endtask

   task automatic op(input logic [1:0] m, input logic [31:0] w);
      modify = m;
      wdata = w;
      tick();
      modify = 2'b00;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && m_left != 0; i++) tick();
      chk("idle_timeout", {31'b0, rdata[8]}, 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int     busy_n;
      int     b2b_base;
      longint g, mx;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_csn", {31'b0, spi_csn}, 32'h1);
      chk("rst_sck", {31'b0, spi_sck}, 32'h0);
      chk("rst_mosi", {31'b0, spi_mosi}, 32'h0);
      rstn = 1'b1;
      tick();
      chk("rst_read", rdata, 32'h0);
      addr = 12'h7c0;
      #1;
      chk("other_valid", {31'b0, valid}, 32'h0);
      chk("other_rdata", rdata, 32'h0);
      addr = CSR_SPI_ADDR;

      // Single transfer A5 out, 3C back
      slv_next = 8'h3c;
      op(2'b01, 32'h0000_03a5);
      chk("csn_at_write", {31'b0, spi_csn}, 32'h0);
      busy_n = 0;
      for (int i = 0; i < 200 && rdata[8]; i++) begin
         busy_n++;
         tick();
      end
      chk("busy_len", busy_n, 32);
      chk("read_3c", rdata, 32'h0000_023c);

      // Write while busy is ignored
      slv_next = 8'h5a;
      op(2'b01, 32'h0000_03a5);
      repeat (4) tick();
      slv_next = 8'hff;
      op(2'b01, 32'h0000_02ff);
      wait_idle();
      repeat (6) tick();
      chk("busy_write_read", rdata, 32'h0000_025a);
      chk("no_second_xfer", rise_n - rise_base, 8);

      // Clear then set
      op(2'b11, 32'h0000_0200);
      chk("clr_csn", {31'b0, spi_csn}, 32'h1);
      chk("clr_busy", {31'b0, rdata[8]}, 32'h0);
      slv_next = 8'h81;
      op(2'b10, 32'h0000_0300);
      chk("set_csn", {31'b0, spi_csn}, 32'h0);
      chk("set_busy", {31'b0, rdata[8]}, 32'h1);
      wait_idle();
      chk("set_read", rdata, 32'h0000_0281);

      // Reset mid-transfer
      slv_next = 8'h77;
      op(2'b01, 32'h0000_03c3);
      repeat (9) tick();
      rstn = 1'b0;
      #1;
      chk("midrst_csn", {31'b0, spi_csn}, 32'h1);
      chk("midrst_sck", {31'b0, spi_sck}, 32'h0);
      m_left = 0;
      m_cs = 1'b0;
      m_rx = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      tick();
      chk("midrst_read", rdata, 32'h0);

      // Back-to-back transfers
      slv_next = 8'hef;
      op(2'b01, 32'h0000_039f);
      b2b_base = rise_base;
      wait_idle();
      chk("b2b_read0", rdata, 32'h0000_02ef);
      slv_next = 8'h40;
      op(2'b01, 32'h0000_0300);
      wait_idle();
      chk("b2b_read1", rdata, 32'h0000_0240);
      slv_next = 8'h16;
      op(2'b01, 32'h0000_0300);
      wait_idle();
      chk("b2b_read2", rdata, 32'h0000_0216);
      chk("b2b_rises", rise_n - b2b_base, 24);
      mx = 0;
      for (int i = b2b_base + 1; i < rise_n; i++) begin
         g = rise_t[i] - rise_t[i-1];
         if (g > mx) mx = g;
      end
      chk("b2b_gap_ok", {31'b0, mx <= longint'((2 * D + 1) * 10)}, 32'h1);

      // Random CSR traffic
      for (int k = 0; k < 60; k++) begin
         addr     = ($urandom_range(0, 3) == 0) ? 12'($urandom) : CSR_SPI_ADDR;
         read     = 1'($urandom);
         slv_next = 8'($urandom);
         op(2'($urandom), $urandom);
         addr = CSR_SPI_ADDR;
         read = 1'b0;
         repeat ($urandom_range(0, 12)) tick();
      end
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
